prefetch_fetch_unit: RTL and testbench
======================================

Name: prefetch_fetch_unit

Overview:
Parametrised instruction-fetch stage for the RV32I pipeline. It replaces the fixed 11-bit, single-cycle, synchronous-ROM fetch with the following:
- a request/grant/response memory interface that tolerates variable memory latency;
- a prefetch FIFO of {pc, instr} entries;
- redirect (branch/jump) flush with discard of in-flight responses;
- a valid/ready handoff to the ID stage.

Parameters:
ADDR_WIDTH, 11, width of PC and instruction address (byte address, 4-byte aligned)
RESET_PC, 0, fetch address after reset
FIFO_DEPTH, 4, prefetch entries; power of 2, >=2
MAX_OUTSTANDING, 2, maximum issued-but-unanswered requests; 1..FIFO_DEPTH

Ports:
clk_i  in  1  clock, rising edge
reset_i  in  1  asynchronous, active-low reset
imem_req_o  in/out: out  1  fetch request valid
imem_gnt_i  in  1  memory accepts the request this cycle
imem_addr_o  out  ADDR_WIDTH  fetch address (bits[1:0] always 00)
imem_rvalid_i  in  1  response valid; responses return in order, at most one per cycle, earliest the cycle after the grant
imem_rdata_i  in  32  instruction word
redirect_i  in  1  flush and restart fetch (taken branch or jump from EX)
redirect_pc_i  in  ADDR_WIDTH  new fetch address; bits[1:0] ignored and treated as 00
id_valid_o  out  1  FIFO head valid for ID
id_ready_i  in  1  ID accepts the head (low means hazard stall)
id_instr_o  out  32  head instruction; 32'h13 when id_valid_o=0
id_pc_o  out  ADDR_WIDTH  head PC; 0 when id_valid_o=0

Behaviour:
- State:
  - fpc: next request address.
  - rpc: PC of the next non-discarded response.
  - outstanding: in-flight request count, 0..MAX_OUTSTANDING.
  - discard: in-flight responses to drop, <= outstanding.
  - FIFO: entries, count, rd/wr pointers.
- Reset (async, reset_i=0):
  - fpc = rpc = RESET_PC; outstanding = discard = count = 0; pointers = 0.
  - Outputs: imem_req_o=0, id_valid_o=0, id_instr_o=32'h13, id_pc_o=0, imem_addr_o=RESET_PC.
  - A reset asserted mid-operation abandons all in-flight requests.
- Request rule:
  - imem_req_o = !redirect_i && (count + outstanding < FIFO_DEPTH) && (outstanding < MAX_OUTSTANDING).
  - imem_addr_o = fpc.
  - On req&&gnt: fpc += 4 (wraps modulo 2^ADDR_WIDTH) and outstanding += 1.
  - req may stay high across cycles without gnt; addr is held stable while waiting.
- Response rule (imem_rvalid_i=1, outstanding>0):
  - outstanding -= 1.
  - If discard>0: discard -= 1 and the data is dropped.
  - Otherwise push {rpc, imem_rdata_i} and rpc += 4 (wrap).
  - rvalid with outstanding==0 is ignored.
- Credit scheme: count + outstanding <= FIFO_DEPTH always, so a push never finds the FIFO full. Push and pop in the same cycle are both legal, and count is unchanged.
- ID handoff:
  - id_valid_o = (count>0) && !redirect_i.
  - Pop on id_valid_o && id_ready_i.
  - The head must remain stable while id_ready_i=0.
  - Latency: a push is registered, so an instruction is visible on id_valid_o the cycle after its rvalid. With a 1-cycle memory, the first instr appears 2 cycles after the first grant.
- Redirect (redirect_i=1, takes priority over everything):
  - FIFO cleared: count=0, pointers reset; no pop occurs.
  - fpc = rpc = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00}.
  - imem_req_o forced 0 that cycle.
  - outstanding_next = outstanding - rvalid_i, and discard_next = outstanding_next: every surviving in-flight response is dropped.
  - A response arriving in the redirect cycle is dropped.
  - Back-to-back redirects: the last one wins; discard is recomputed each cycle.
- Invariants: discard <= outstanding <= MAX_OUTSTANDING; count <= FIFO_DEPTH.
- Sizing: count is $clog2(FIFO_DEPTH)+1 bits; outstanding and discard are $clog2(MAX_OUTSTANDING)+1 bits.

Test Plan:
1. Reset, gnt tied 1, 1-cycle rvalid, id_ready=1, memory word = address: id_pc_o follows 0,4,8,12 on consecutive cycles with id_instr_o equal to id_pc_o. The first id_valid_o occurs 2 cycles after the first grant.
2. id_ready=0 held for 10 cycles: exactly FIFO_DEPTH (4) entries are captured, imem_req_o drops to 0, and the head stays pc=0. On release, entries 0,4,8,12 drain in order with no loss or duplication.
3. Memory latency 3 cycles, MAX_OUTSTANDING=2: outstanding never exceeds 2, and imem_req_o is low while 2 requests are pending. Order is still 0,4,8.
4. redirect_i with redirect_pc_i=0x103 while 2 requests are outstanding and the FIFO holds 2 entries:
   - id_valid_o=0 in the redirect cycle;
   - the next 2 rvalids are dropped;
   - the next delivered pc is 0x100, then 0x104.
5. Redirect in the same cycle as an rvalid, with outstanding=1: that response is dropped, discard=0, and fetch resumes at the new PC immediately the next cycle.
6. ADDR_WIDTH=11, redirect to 0x7FC: pcs 0x7FC then 0x000 (wrap). Asserting reset_i=0 mid-burst returns all outputs to reset values asynchronously; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/prefetch_fetch_unit.sv
// Instruction-fetch stage: issues word fetches over a req/gnt/rvalid memory
// port, buffers {pc, instr} pairs in a small prefetch FIFO and hands them to
// ID over valid/ready. Redirects flush the FIFO and drop in-flight responses.
module prefetch_fetch_unit #(
   parameter int unsigned           ADDR_WIDTH      = 11,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0,
   parameter int unsigned           FIFO_DEPTH      = 4,
   parameter int unsigned           MAX_OUTSTANDING = 2
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   output logic                  imem_req_o,
   input  logic                  imem_gnt_i,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   input  logic                  imem_rvalid_i,
   input  logic [31:0]           imem_rdata_i,
   input  logic                  redirect_i,
   input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
   output logic                  id_valid_o,
   input  logic                  id_ready_i,
   output logic [31:0]           id_instr_o,
   output logic [ADDR_WIDTH-1:0] id_pc_o
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING) + 1;

   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
   localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] RESET_PC_A = RESET_PC & ALIGN_MASK;
   localparam logic [CNT_W:0]        DEPTH_C    = (CNT_W+1)'(FIFO_DEPTH);
   localparam logic [OUT_W-1:0]      MAX_OUT_C  = OUT_W'(MAX_OUTSTANDING);
   localparam logic [31:0]           NOP_INSTR  = 32'h0000_0013;

   logic [ADDR_WIDTH-1:0] fpc_q, fpc_d;
   logic [ADDR_WIDTH-1:0] rpc_q, rpc_d;
   logic [OUT_W-1:0]      outstanding_q, outstanding_d;
   logic [OUT_W-1:0]      discard_q, discard_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;

   logic [ADDR_WIDTH-1:0] fifo_pc_q    [FIFO_DEPTH];
   logic [31:0]           fifo_instr_q [FIFO_DEPTH];

   logic [CNT_W:0] credit_used;
   logic           req;
   logic           id_valid;
   logic           gnt_fire;
   logic           rsp_fire;
   logic           push;
   logic           pop;

   // Handshake qualification and next-state for PCs, credits and FIFO pointers.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      fpc_d         = fpc_q;
      rpc_d         = rpc_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;

      // Request only while every in-flight response is guaranteed a FIFO slot.
      credit_used = (CNT_W+1)'(count_q) + (CNT_W+1)'(outstanding_q);
      req         = reset_i && !redirect_i && (credit_used < DEPTH_C)
                    && (outstanding_q < MAX_OUT_C);
      id_valid    = (count_q != '0) && !redirect_i;

      gnt_fire = req && imem_gnt_i;
      rsp_fire = imem_rvalid_i && (outstanding_q != '0);
      pop      = id_valid && id_ready_i;
      push     = rsp_fire && (discard_q == '0) && !redirect_i;

      if (redirect_i) begin
         // Restart at the new target; everything still in flight is stale.
         fpc_d         = redirect_pc_i & ALIGN_MASK;
         rpc_d         = redirect_pc_i & ALIGN_MASK;
         outstanding_d = outstanding_q - OUT_W'(rsp_fire);
         discard_d     = outstanding_q - OUT_W'(rsp_fire);
         count_d       = '0;
         rd_ptr_d      = '0;
         wr_ptr_d      = '0;
      end else begin
         if (gnt_fire) begin
            fpc_d = fpc_q + PC_STEP;
         end
         outstanding_d = outstanding_q + OUT_W'(gnt_fire) - OUT_W'(rsp_fire);
         if (rsp_fire && (discard_q != '0)) begin
            discard_d = discard_q - OUT_W'(1);
         end
         if (push) begin
            rpc_d    = rpc_q + PC_STEP;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Control state registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         fpc_q         <= RESET_PC_A;
         rpc_q         <= RESET_PC_A;
         outstanding_q <= '0;
         discard_q     <= '0;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
         fpc_q         <= fpc_d;
         rpc_q         <= rpc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
      end
   end

   // Prefetch storage write port.
   // NOTE: the entry array is not reset; count_q gates every read, so stale contents are never visible.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_pc_q[wr_ptr_q]    <= rpc_q;
         fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
      end
   end

   assign imem_req_o  = req;
   assign imem_addr_o = fpc_q;
   assign id_valid_o  = id_valid;
   assign id_instr_o  = id_valid ? fifo_instr_q[rd_ptr_q] : NOP_INSTR;
   assign id_pc_o     = id_valid ? fifo_pc_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// Self-checking bench for prefetch_fetch_unit: a latency-randomised memory
// model, a scoreboard of expected {pc, instr} filled at grant time, and a
// separate monitor that pops and compares on every ID handshake.
module tb_prefetch_fetch_unit;

   localparam int AW     = 11;
   localparam int ASPACE = 1 << AW;
   localparam int DEPTH  = 4;
   localparam int MAXOUT = 2;

   typedef struct { int addr; int due; bit stale; } pend_t;
   typedef struct { int pc; logic [31:0] instr; } exp_t;

   logic          clk_i = 1'b0;
   logic          reset_i = 1'b0;
   logic          imem_req_o;
   logic          imem_gnt_i = 1'b0;
   logic [AW-1:0] imem_addr_o;
   logic          imem_rvalid_i = 1'b0;
   logic [31:0]   imem_rdata_i = '0;
   logic          redirect_i = 1'b0;
   logic [AW-1:0] redirect_pc_i = '0;
   logic          id_valid_o;
   logic          id_ready_i = 1'b0;
   logic [31:0]   id_instr_o;
   logic [AW-1:0] id_pc_o;

   prefetch_fetch_unit #(
      .ADDR_WIDTH(AW), .RESET_PC('0), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXOUT)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .imem_req_o(imem_req_o), .imem_gnt_i(imem_gnt_i), .imem_addr_o(imem_addr_o),
      .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
      .id_instr_o(id_instr_o), .id_pc_o(id_pc_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;

   // Reference model state
   pend_t pending[$];
   exp_t  sb[$];
   int    post_pcs[$];
   int    fifo_cnt  = 0;
   int    model_fpc = 0;
   int    cyc       = 0;

   // Stimulus knobs
   int gnt_pct = 100, rv_pct = 100, ready_pct = 100, redir_pm = 0;
   int lat_min = 1, lat_max = 1;
   bit spurious = 0;
   bit force_redir = 0;
   int force_pc = 0;
   bit last_grant, last_hs;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_word(input int a);
      return 32'hC0DE_0000 ^ (32'(a) * 32'h0001_0003);
   endfunction

   // One clock of stimulus plus model bookkeeping; returns at negedge+1.
   task automatic cycle();
      bit    rsp, grant, hs, exp_req;
      int    lat;
      pend_t e;
      @(negedge clk_i);
      cyc++;
      if (force_redir) begin
         redirect_i    = 1'b1;
         redirect_pc_i = AW'(force_pc);
         force_redir   = 1'b0;
      end else begin
         redirect_i    = ($urandom_range(999) < redir_pm);
         redirect_pc_i = AW'($urandom);
      end
      id_ready_i    = ($urandom_range(99) < ready_pct);
      imem_gnt_i    = ($urandom_range(99) < gnt_pct);
      imem_rdata_i  = $urandom;
      imem_rvalid_i = 1'b0;
      rsp = 0;
      if (pending.size() > 0) begin
         if (pending[0].due <= cyc && $urandom_range(99) < rv_pct) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(pending[0].addr);
            rsp = 1;
         end
      end else if (spurious && $urandom_range(99) < 15) begin
         imem_rvalid_i = 1'b1;
      end
      #1;
      exp_req = !redirect_i && (fifo_cnt + pending.size() < DEPTH) && (pending.size() < MAXOUT);
      check("imem_req", 32'(imem_req_o), 32'(exp_req));
      check("id_valid", 32'(id_valid_o), 32'(fifo_cnt > 0 && !redirect_i));
      if (!id_valid_o) begin
         check("idle_instr", id_instr_o, 32'h13);
         check("idle_pc", 32'(id_pc_o), 32'h0);
      end
      grant = imem_req_o && imem_gnt_i;
      hs    = id_valid_o && id_ready_i;
      last_grant = grant;
      last_hs    = hs;
      if (hs) begin
         fifo_cnt--;
         post_pcs.push_back(int'(id_pc_o));
      end
      if (rsp) begin
         e = pending.pop_front();
         if (!e.stale && !redirect_i) fifo_cnt++;
      end
      if (grant) begin
         check("fetch_addr", 32'(imem_addr_o), 32'(model_fpc));
         lat = $urandom_range(lat_max, lat_min);
         pending.push_back('{addr: model_fpc, due: cyc + lat, stale: 1'b0});
         sb.push_back('{pc: model_fpc, instr: mem_word(model_fpc)});
         model_fpc = (model_fpc + 4) % ASPACE;
      end
      if (redirect_i) begin
         foreach (pending[i]) pending[i].stale = 1'b1;
         fifo_cnt = 0;
         sb.delete();
         post_pcs.delete();
         model_fpc = int'(redirect_pc_i) & ~3;
      end
   endtask

   task automatic drain();
      int i;
      gnt_pct = 0; ready_pct = 100; redir_pm = 0; rv_pct = 100;
      i = 0;
      while (i < 60 && !(pending.size() == 0 && fifo_cnt == 0)) begin
         cycle();
         i++;
      end
      check("drain_done", 32'(pending.size() == 0 && fifo_cnt == 0), 32'h1);
   endtask

   task automatic wait_post(input int n);
      int i;
      i = 0;
      while (i < 40 && post_pcs.size() < n) begin
         cycle();
         i++;
      end
      check("post_pcs_arrived", 32'(post_pcs.size() >= n), 32'h1);
   endtask

   task automatic reset_mid();
      @(posedge clk_i);
      #3;
      reset_i       = 1'b0;
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      redirect_i    = 1'b0;
      #1;
      check("rst_req", 32'(imem_req_o), 32'h0);
      check("rst_valid", 32'(id_valid_o), 32'h0);
      check("rst_instr", id_instr_o, 32'h13);
      check("rst_pc", 32'(id_pc_o), 32'h0);
      check("rst_addr", 32'(imem_addr_o), 32'h0);
      pending.delete();
      sb.delete();
      post_pcs.delete();
      fifo_cnt  = 0;
      model_fpc = 0;
      @(negedge clk_i);
      reset_i = 1'b1;
   endtask

   // Monitor: pops the scoreboard on every accepted ID handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         #2;
         if (reset_i && id_valid_o && id_ready_i) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_underflow: got pc %h with nothing expected", id_pc_o);
            end else begin
               e = sb.pop_front();
               check("id_pc", 32'(id_pc_o), 32'(e.pc));
               check("id_instr", id_instr_o, e.instr);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int g0, h0, last_h, nhs, grants;

      // Reset values while held in reset.
      repeat (3) @(negedge clk_i);
      check("init_req", 32'(imem_req_o), 32'h0);
      check("init_valid", 32'(id_valid_o), 32'h0);
      check("init_instr", id_instr_o, 32'h13);
      check("init_pc", 32'(id_pc_o), 32'h0);
      check("init_addr", 32'(imem_addr_o), 32'h0);
      reset_i = 1'b1;

      // 1-cycle memory, always granted, ID always ready.
      g0 = -1; h0 = -1; last_h = -1; nhs = 0;
      for (int i = 0; i < 16; i++) begin
         cycle();
         if (last_grant && g0 < 0) g0 = cyc;
         if (last_hs) begin
            if (h0 < 0) h0 = cyc;
            last_h = cyc;
            nhs++;
         end
      end
      check("first_valid_latency", 32'(h0 - g0), 32'd2);
      check("no_bubbles", 32'(nhs), 32'(last_h - h0 + 1));
      check("seq0", 32'(post_pcs[0]), 32'h0);
      check("seq1", 32'(post_pcs[1]), 32'h4);
      check("seq2", 32'(post_pcs[2]), 32'h8);
      check("seq3", 32'(post_pcs[3]), 32'hC);

      // ID stall: exactly FIFO_DEPTH fetches captured, head held stable.
      drain();
      gnt_pct = 100; ready_pct = 0; lat_min = 1; lat_max = 1;
      grants = 0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (last_grant) grants++;
         if (id_valid_o && sb.size() > 0) check("stall_head", 32'(id_pc_o), 32'(sb[0].pc));
      end
      check("stall_fill", 32'(grants), 32'(DEPTH));
      ready_pct = 100;
      repeat (10) cycle();

      // 3-cycle memory: outstanding capped by MAX_OUTSTANDING.
      lat_min = 3; lat_max = 3;
      repeat (25) cycle();

      // Redirect to 0x103 with 2 outstanding and 2 buffered.
      drain();
      lat_min = 3; lat_max = 3; gnt_pct = 100; ready_pct = 0;
      for (int i = 0; i < 40 && !(fifo_cnt == 2 && pending.size() == 2); i++) cycle();
      check("d_setup", 32'(fifo_cnt == 2 && pending.size() == 2), 32'h1);
      force_redir = 1'b1; force_pc = 'h103;
      cycle();
      check("d_valid_in_redirect", 32'(id_valid_o), 32'h0);
      check("d_req_in_redirect", 32'(imem_req_o), 32'h0);
      ready_pct = 100;
      wait_post(2);
      check("d_pc0", 32'(post_pcs[0]), 32'h100);
      check("d_pc1", 32'(post_pcs[1]), 32'h104);

      // Redirect coinciding with the only outstanding response.
      drain();
      lat_min = 2; lat_max = 2; gnt_pct = 100;
      cycle();
      check("e_grant", 32'(last_grant), 32'h1);
      gnt_pct = 0;
      cycle();
      force_redir = 1'b1; force_pc = 'h200;
      cycle();
      check("e_rvalid_in_redirect", 32'(imem_rvalid_i), 32'h1);
      gnt_pct = 100;
      cycle();
      check("e_req_after", 32'(imem_req_o), 32'h1);
      check("e_addr_after", 32'(imem_addr_o), 32'h200);
      wait_post(1);
      check("e_pc0", 32'(post_pcs[0]), 32'h200);

      // Address wrap at the top of the space.
      lat_min = 1; lat_max = 1;
      force_redir = 1'b1; force_pc = 'h7FC;
      cycle();
      wait_post(2);
      check("f_pc0", 32'(post_pcs[0]), 32'h7FC);
      check("f_pc1", 32'(post_pcs[1]), 32'h000);

      // Randomised traffic with a mid-burst asynchronous reset.
      gnt_pct = 70; rv_pct = 70; ready_pct = 70; redir_pm = 30;
      lat_min = 1; lat_max = 4; spurious = 1;
      repeat (250) cycle();
      reset_mid();
      repeat (250) cycle();

      // Final drain: every expected entry must come out.
      spurious = 0; redir_pm = 0; gnt_pct = 0; ready_pct = 100; rv_pct = 100;
      for (int i = 0; i < 200 && sb.size() > 0; i++) cycle();
      check("final_sb_empty", 32'(sb.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
